rd_xfr_sequencer: RTL and testbench

RD_XFR_SEQUENCER -- requirements
Module: rd_xfr_sequencer

---
 rtl/rd_xfr_sequencer.sv | 138 +++++++++++++
 tb/tb_rd_xfr_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_xfr_sequencer.sv
// Read-transfer sequencer: triggers RD, waits for ENABLE_XFR, measures its length, reports the result.
// Optional macro RD_XFR_TIMEOUT_EN adds a WAIT-state timeout (result code 1).
`timescale 1ns/1ps
module rd_xfr_sequencer #(
    parameter int TRIG_WIDTH     = 4,
    parameter int XFR_BITS       = 26624,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        LOCAL_CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        EVENT_TRIG,
    input  logic        RD_XFR,
    output logic        RD_ENABLE,
    output logic        RD_TRIGGER,
    output logic        BUSY,
    output logic        PENDING,
    output logic        XFR_DONE,
    output logic [1:0]  XFR_ERR,
    output logic [15:0] XFR_COUNT,
    output logic [2:0]  STATE_DBG
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [15:0] XFR_BITS_W = 16'(XFR_BITS);
    localparam logic [3:0]  TRIG_LAST  = 4'(TRIG_WIDTH - 1);

    state_t      state, state_nxt;
    logic [1:0]  done_code;
    logic        xfr_meta, xfr_sync;
    logic        wait_low;
    logic [3:0]  trig_cnt;
    logic [15:0] bit_cnt;

`ifdef RD_XFR_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // wait_low makes a rise count only after RD_XFR has been seen low inside WAIT
    always_comb begin
        state_nxt = state;
        done_code = 2'd0;
        if (!ENABLE) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (EVENT_TRIG || PENDING) state_nxt = ST_TRIG;
                ST_TRIG: if (trig_cnt == TRIG_LAST) state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (wait_low && xfr_sync) begin
                        state_nxt = ST_XFER;
                    end
`ifdef RD_XFR_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state_nxt = ST_DONE;
                        done_code = 2'd1;
                    end
`endif
                end
                ST_XFER: begin
                    if (!xfr_sync) begin
                        state_nxt = ST_DONE;
                        done_code = (bit_cnt == XFR_BITS_W) ? 2'd0 : 2'd2;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge LOCAL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            xfr_meta  <= 1'b0;
            xfr_sync  <= 1'b0;
            RD_ENABLE <= 1'b0;
            PENDING   <= 1'b0;
            wait_low  <= 1'b0;
            trig_cnt  <= 4'd0;
            bit_cnt   <= 16'd0;
            XFR_ERR   <= 2'd0;
            XFR_COUNT <= 16'd0;
`ifdef RD_XFR_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            xfr_meta  <= RD_XFR;
            xfr_sync  <= xfr_meta;
            RD_ENABLE <= ENABLE;

            // In IDLE with ENABLE high a queued request is always consumed
            if (!ENABLE || state == ST_IDLE) PENDING <= 1'b0;
            else if (EVENT_TRIG)             PENDING <= 1'b1;

            if (state == ST_TRIG) trig_cnt <= trig_cnt + 4'd1;
            else                  trig_cnt <= 4'd0;

            if (state != ST_WAIT) wait_low <= 1'b0;
            else if (!xfr_sync)   wait_low <= 1'b1;

`ifdef RD_XFR_TIMEOUT_EN
            if (state == ST_WAIT) to_cnt <= to_cnt + TO_W'(1);
            else                  to_cnt <= '0;
`endif

            // The rising sample seen in WAIT is the first high bit
            if (state == ST_WAIT && state_nxt == ST_XFER)
                bit_cnt <= 16'd1;
            else if (state == ST_XFER && xfr_sync && bit_cnt != 16'hFFFF)
                bit_cnt <= bit_cnt + 16'd1;

            if (state_nxt == ST_DONE) begin
                XFR_ERR <= done_code;
                if (done_code == 2'd0) XFR_COUNT <= XFR_COUNT + 16'd1;
            end
        end
    end

    assign RD_TRIGGER = (state == ST_TRIG);
    assign BUSY       = (state != ST_IDLE);
    assign XFR_DONE   = (state == ST_DONE);
    assign STATE_DBG  = state;

endmodule

// File: tb/tb_rd_xfr_sequencer.sv
// Directed + randomized bench for rd_xfr_sequencer with a queue-based result model.
// Build with RD_XFR_TIMEOUT_EN defined or not; the timeout step adapts.
`timescale 1ns/1ps
module tb_rd_xfr_sequencer;
    localparam int TW = 4;
    localparam int XB = 64;
    localparam int TO = 32;

    logic        LOCAL_CLK = 1'b0;
    logic        RESET_N, ENABLE, EVENT_TRIG, RD_XFR;
    logic        RD_ENABLE, RD_TRIGGER, BUSY, PENDING, XFR_DONE;
    logic [1:0]  XFR_ERR;
    logic [15:0] XFR_COUNT;
    logic [2:0]  STATE_DBG;

    always #5 LOCAL_CLK = ~LOCAL_CLK;

    rd_xfr_sequencer #(.TRIG_WIDTH(TW), .XFR_BITS(XB), .TIMEOUT_CYCLES(TO)) dut (
        .LOCAL_CLK(LOCAL_CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .EVENT_TRIG(EVENT_TRIG),
        .RD_XFR(RD_XFR), .RD_ENABLE(RD_ENABLE), .RD_TRIGGER(RD_TRIGGER), .BUSY(BUSY),
        .PENDING(PENDING), .XFR_DONE(XFR_DONE), .XFR_ERR(XFR_ERR), .XFR_COUNT(XFR_COUNT),
        .STATE_DBG(STATE_DBG)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] exp_q[$];
    int         model_count = 0;
    int         done_seen = 0;
    logic [1:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result: exact length is OK, anything else is a length mismatch
    function automatic logic [1:0] exp_code(input int len);
        return (len == XB) ? 2'd0 : 2'd2;
    endfunction

    // Scoreboard: every completion pulse must match the oldest expected result
    always @(negedge LOCAL_CLK) begin
        if (!RESET_N) begin
            model_count = 0;
        end else if (XFR_DONE === 1'b1) begin
            done_seen++;
            chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                if (mon_exp == 2'd0) model_count = (model_count + 1) & 16'hFFFF;
                chk("xfr_err", 32'(XFR_ERR), 32'(mon_exp));
                chk("xfr_count", 32'(XFR_COUNT), 32'(model_count));
            end
        end
    end

    task automatic tick();
        @(negedge LOCAL_CLK);
    endtask

    task automatic pulse_event();
        EVENT_TRIG = 1'b1;
        tick();
        EVENT_TRIG = 1'b0;
    endtask

    // Request at cycle N: trigger must be high exactly N+1..N+TW; returns in first WAIT cycle
    task automatic trig_and_check(input string tag);
        chk({tag, "_idle_before"}, 32'(BUSY), 32'd0);
        pulse_event();
        for (int i = 0; i < TW; i++) begin
            chk({tag, "_trig_hi"}, 32'(RD_TRIGGER), 32'd1);
            if (i == 0) chk({tag, "_busy_hi"}, 32'(BUSY), 32'd1);
            tick();
        end
        chk({tag, "_trig_lo"}, 32'(RD_TRIGGER), 32'd0);
        chk({tag, "_busy_wait"}, 32'(BUSY), 32'd1);
    endtask

    task automatic drive_xfer(input int len, input int gap);
        repeat (gap) tick();
        RD_XFR = 1'b1;
        repeat (len) tick();
        RD_XFR = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (XFR_DONE !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk({tag, "_done_seen"}, 32'(XFR_DONE), 32'd1);
    endtask

    task automatic run_xfer(input string tag, input int len, input int gap);
        int c;
        exp_q.push_back(exp_code(len));
        trig_and_check(tag);
        drive_xfer(len, gap);
        wait_done(tag, 20, c);
        tick();
        chk({tag, "_idle_after"}, 32'(BUSY), 32'd0);
    endtask

    int c, d0, busy_cycles, len, gap, sel;

    initial begin
        RESET_N = 1'b0; ENABLE = 1'b0; EVENT_TRIG = 1'b0; RD_XFR = 1'b0;
        repeat (3) tick();
        chk("rst_rd_enable", 32'(RD_ENABLE), 32'd0);
        chk("rst_rd_trigger", 32'(RD_TRIGGER), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_pending", 32'(PENDING), 32'd0);
        chk("rst_xfr_done", 32'(XFR_DONE), 32'd0);
        chk("rst_xfr_err", 32'(XFR_ERR), 32'd0);
        chk("rst_xfr_count", 32'(XFR_COUNT), 32'd0);

        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        tick();
        chk("rd_enable_follow", 32'(RD_ENABLE), 32'd1);
        repeat (6) tick();

        run_xfer("exact", XB, 3);
        run_xfer("short", XB - 1, 2);
        run_xfer("long", XB + 1, 1);

        for (int k = 0; k < 6; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       len = XB;
                1:       len = XB - 1;
                2:       len = XB + 1;
                default: len = $urandom_range(1, XB + 5);
            endcase
            gap = $urandom_range(1, 6);
            run_xfer("rand", len, gap);
        end

        // Three requests during a transfer: one queued, the rest dropped
        exp_q.push_back(2'd0);
        trig_and_check("pend");
        RD_XFR = 1'b1;
        repeat (10) tick();
        pulse_event();
        chk("pend_set1", 32'(PENDING), 32'd1);
        repeat (5) tick();
        pulse_event();
        chk("pend_set2", 32'(PENDING), 32'd1);
        repeat (5) tick();
        pulse_event();
        chk("pend_set3", 32'(PENDING), 32'd1);
        repeat (XB - 23) tick();
        RD_XFR = 1'b0;
        wait_done("pend_first", 20, c);
        chk("pend_at_done", 32'(PENDING), 32'd1);
        exp_q.push_back(2'd0);
        c = 0;
        while (RD_TRIGGER !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        chk("pend_extra_trig", 32'(RD_TRIGGER), 32'd1);
        chk("pend_cleared", 32'(PENDING), 32'd0);
        repeat (TW) tick();
        drive_xfer(XB, 2);
        wait_done("pend_second", 20, c);
        busy_cycles = 0;
        repeat (30) begin
            tick();
            if (BUSY) busy_cycles++;
        end
        chk("third_dropped", 32'(busy_cycles), 32'd0);

        // Request in the DONE cycle is queued and served straight from IDLE
        exp_q.push_back(2'd0);
        trig_and_check("donereq");
        drive_xfer(XB, 1);
        wait_done("donereq", 20, c);
        EVENT_TRIG = 1'b1;
        tick();
        chk("donereq_pending", 32'(PENDING), 32'd1);
        chk("donereq_idle", 32'(BUSY), 32'd0);
        EVENT_TRIG = 1'b0;
        tick();
        chk("donereq_trig", 32'(RD_TRIGGER), 32'd1);
        chk("donereq_pend_clr", 32'(PENDING), 32'd0);
        len = $urandom_range(XB - 2, XB + 2);
        exp_q.push_back(exp_code(len));
        repeat (TW) tick();
        drive_xfer(len, 1);
        wait_done("donereq_second", 20, c);
        tick();

        // ENABLE dropped mid-transfer: abort with no completion
        trig_and_check("endrop");
        RD_XFR = 1'b1;
        repeat (8) tick();
        pulse_event();
        chk("endrop_pend", 32'(PENDING), 32'd1);
        d0 = done_seen;
        ENABLE = 1'b0;
        tick();
        chk("endrop_busy", 32'(BUSY), 32'd0);
        chk("endrop_pending", 32'(PENDING), 32'd0);
        chk("endrop_rd_enable", 32'(RD_ENABLE), 32'd0);
        repeat (3) tick();
        RD_XFR = 1'b0;
        repeat (6) tick();
        pulse_event();
        tick();
        chk("endrop_evt_ignored", 32'(BUSY), 32'd0);
        chk("endrop_evt_no_pend", 32'(PENDING), 32'd0);
        chk("endrop_no_done", 32'(done_seen - d0), 32'd0);
        chk("endrop_count", 32'(XFR_COUNT), 32'(model_count));
        ENABLE = 1'b1;
        repeat (2) tick();

        // Reset pulsed mid-transfer: everything clears asynchronously
        trig_and_check("rstmid");
        RD_XFR = 1'b1;
        repeat (20) tick();
        d0 = done_seen;
        #2 RESET_N = 1'b0;
        #1;
        chk("rstmid_busy", 32'(BUSY), 32'd0);
        chk("rstmid_pending", 32'(PENDING), 32'd0);
        chk("rstmid_rd_enable", 32'(RD_ENABLE), 32'd0);
        chk("rstmid_err", 32'(XFR_ERR), 32'd0);
        chk("rstmid_count", 32'(XFR_COUNT), 32'd0);
        repeat (2) tick();
        RD_XFR = 1'b0;
        RESET_N = 1'b1;
        repeat (5) tick();
        chk("rstmid_no_done", 32'(done_seen - d0), 32'd0);
        run_xfer("after_rst", XB, 2);

        // WAIT with no rise
`ifdef RD_XFR_TIMEOUT_EN
        exp_q.push_back(2'd1);
        trig_and_check("tmo");
        wait_done("tmo", TO + 20, c);
        chk("tmo_cycles", 32'(c), 32'(TO));
        tick();
        chk("tmo_idle", 32'(BUSY), 32'd0);
`else
        trig_and_check("notmo");
        d0 = done_seen;
        c = 0;
        repeat (3 * TO) begin
            tick();
            if (!BUSY) c++;
        end
        chk("notmo_busy", 32'(c), 32'd0);
        chk("notmo_no_done", 32'(done_seen - d0), 32'd0);
        ENABLE = 1'b0;
        tick();
        chk("notmo_abort", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;
        tick();
`endif

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
